// File: rtl/graphics_if.sv
// Button, frame-tick and committed-output bundle between the pattern stage and its control sequencer.
interface graphics_if;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       sel;
   logic       frame_tick;
   logic [1:0] pattern_sel;
   logic [9:0] obj_x;
   logic [9:0] obj_y;
   logic       update;

   modport master (
      output up, down, left, right, sel, frame_tick,
      input  pattern_sel, obj_x, obj_y, update
   );

   modport slave (
      input  up, down, left, right, sel, frame_tick,
      output pattern_sel, obj_x, obj_y, update
   );
endinterface

// File: rtl/graphics_ctrl.sv
// Debounces buttons into pending requests and commits them once per frame to object position and pattern.
// Optional AUTO_CYCLE_EN adds a frame counter that advances the pattern every AUTO_FRAMES frames.
//
// state  | meaning
// IDLE   | collect pending presses, wait for frame_tick
// COMMIT | apply pending snapshot to outputs, clear pending (1 cycle)
module graphics_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int OBJ_W           = 32,
    parameter int OBJ_H           = 32,
    parameter int STEP            = 8,
    parameter int NUM_PATTERNS    = 4
`ifdef AUTO_CYCLE_EN
    ,
    parameter int AUTO_FRAMES     = 120
`endif
) (
    input logic     clk,
    input logic     reset,
    graphics_if.slave gfx
);

    localparam int             CW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  DB_RELOAD = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]     X_MAX     = 10'(H_ACTIVE - OBJ_W);
    localparam logic [9:0]     Y_MAX     = 10'(V_ACTIVE - OBJ_H);
    localparam logic [9:0]     X_INIT    = 10'((H_ACTIVE - OBJ_W) / 2);
    localparam logic [9:0]     Y_INIT    = 10'((V_ACTIVE - OBJ_H) / 2);
    localparam logic [9:0]     STEP_V    = 10'(STEP);
    localparam logic [1:0]     PAT_LAST  = 2'(NUM_PATTERNS - 1);

    localparam int B_UP = 0, B_DOWN = 1, B_LEFT = 2, B_RIGHT = 3, B_SEL = 4;

    typedef enum logic {IDLE, COMMIT} state_t;

    state_t        state, state_nx;
    logic [4:0]    btn_raw, sync1, sync2, db, db_prev, rise;
    logic [CW-1:0] db_cnt [5];
    logic [4:0]    pend, pend_nx;
    logic [9:0]    obj_x_q, obj_y_q, x_nx, y_nx;
    logic [1:0]    pat_q, pat_nx;
    logic          upd_q, upd_nx;
    logic          adv;
    logic [10:0]   x_inc, y_inc;

    assign btn_raw = {gfx.sel, gfx.right, gfx.left, gfx.down, gfx.up};
    assign rise    = db & ~db_prev;
    assign x_inc   = {1'b0, obj_x_q} + {1'b0, STEP_V};
    assign y_inc   = {1'b0, obj_y_q} + {1'b0, STEP_V};

    // Counter reloads whenever the synced level matches the accepted level, so any bounce restarts the wait.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= DB_RELOAD;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= DB_RELOAD;
                end else if (db_cnt[i] == '0) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= DB_RELOAD;
                end else begin
                    db_cnt[i] <= db_cnt[i] - 1'b1;
                end
            end
        end
    end

`ifdef AUTO_CYCLE_EN
    localparam int            FCW    = $clog2(AUTO_FRAMES + 1);
    localparam logic [FCW-1:0] FC_MAX = FCW'(AUTO_FRAMES);
    logic [FCW-1:0] fcnt, fcnt_nx;

    always_ff @(posedge clk) begin
        if (!reset) fcnt <= '0;
        else        fcnt <= fcnt_nx;
    end

    always_comb begin
        fcnt_nx = fcnt;
        if (state == IDLE && gfx.frame_tick && fcnt != FC_MAX) fcnt_nx = fcnt + 1'b1;
        if (state == COMMIT && adv)                           fcnt_nx = '0;
    end

    assign adv = pend[B_SEL] | (fcnt == FC_MAX);
`else
    assign adv = pend[B_SEL];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pend    <= '0;
            obj_x_q <= X_INIT;
            obj_y_q <= Y_INIT;
            pat_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            obj_x_q <= x_nx;
            obj_y_q <= y_nx;
            pat_q   <= pat_nx;
            upd_q   <= upd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pend_nx  = pend | rise;
        x_nx     = obj_x_q;
        y_nx     = obj_y_q;
        pat_nx   = pat_q;
        upd_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (gfx.frame_tick) state_nx = COMMIT;
            end
            COMMIT: begin
                state_nx = IDLE;
                // Edges landing in this cycle survive the clear and go to the next frame.
                pend_nx  = rise;
                if (pend[B_LEFT] && !pend[B_RIGHT])
                    x_nx = (obj_x_q < STEP_V) ? 10'd0 : obj_x_q - STEP_V;
                else if (pend[B_RIGHT] && !pend[B_LEFT])
                    x_nx = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
                if (pend[B_UP] && !pend[B_DOWN])
                    y_nx = (obj_y_q < STEP_V) ? 10'd0 : obj_y_q - STEP_V;
                else if (pend[B_DOWN] && !pend[B_UP])
                    y_nx = (y_inc > {1'b0, Y_MAX}) ? Y_MAX : y_inc[9:0];
                if (adv)
                    pat_nx = (pat_q == PAT_LAST) ? 2'd0 : pat_q + 2'd1;
                upd_nx = (x_nx != obj_x_q) || (y_nx != obj_y_q) || (pat_nx != pat_q);
            end
            default: state_nx = IDLE;
        endcase
    end

    assign gfx.pattern_sel = pat_q;
    assign gfx.obj_x       = obj_x_q;
    assign gfx.obj_y       = obj_y_q;
    assign gfx.update      = upd_q;

endmodule

// File: tb/tb_graphics_ctrl.sv
// Scoreboard bench for graphics_ctrl: stimulus pushes expected commits, a monitor checks each update pulse.
module tb_graphics_ctrl;
    localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LF = 5'b00100,
                           M_RT = 5'b01000, M_SEL = 5'b10000;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    graphics_if gfx();

    graphics_ctrl #(
        .DEBOUNCE_CYCLES(4), .STEP(8), .OBJ_W(32), .OBJ_H(32), .NUM_PATTERNS(4)
`ifdef AUTO_CYCLE_EN
        , .AUTO_FRAMES(3)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .gfx(gfx)
    );

    typedef struct {
        logic [1:0] p;
        logic [9:0] x;
        logic [9:0] y;
        int         cyc;
    } exp_t;

    exp_t sbq[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gfx.update === 1'b1) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_update got p=%0d x=%0d y=%0d cyc=%0d required no update",
                             gfx.pattern_sel, gfx.obj_x, gfx.obj_y, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (gfx.pattern_sel !== e.p || gfx.obj_x !== e.x || gfx.obj_y !== e.y || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL commit got p=%0d x=%0d y=%0d cyc=%0d required p=%0d x=%0d y=%0d cyc=%0d",
                                 gfx.pattern_sel, gfx.obj_x, gfx.obj_y, cyc, e.p, e.x, e.y, e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [1:0] p, input logic [9:0] x,
                       input logic [9:0] y, input logic u);
        total++;
        if (gfx.pattern_sel !== p || gfx.obj_x !== x || gfx.obj_y !== y || gfx.update !== u) begin
            bad++;
            $display("FAIL %s got p=%0d x=%0d y=%0d upd=%0d required p=%0d x=%0d y=%0d upd=%0d",
                     nm, gfx.pattern_sel, gfx.obj_x, gfx.obj_y, gfx.update, p, x, y, u);
        end
    endtask

    task automatic set_btn(input logic [4:0] m);
        gfx.up    = m[0];
        gfx.down  = m[1];
        gfx.left  = m[2];
        gfx.right = m[3];
        gfx.sel   = m[4];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 2'd0, 10'd304, 10'd224, 1'b0);
        reset = 1'b1;
    endtask

    task automatic press(input logic [4:0] m);
        @(posedge clk); #1;
        set_btn(m);
        repeat (10) @(posedge clk);
        #1 set_btn(5'b0);
        repeat (10) @(posedge clk);
    endtask

    task automatic tick(input string nm, input logic upd, input logic [1:0] p,
                        input logic [9:0] x, input logic [9:0] y);
        exp_t e;
        @(posedge clk); #1;
        gfx.frame_tick = 1'b1;
        if (upd) begin
            e.p = p; e.x = x; e.y = y; e.cyc = cyc + 2;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        gfx.frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk(nm, p, x, y, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        set_btn(5'b0);
        gfx.frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

`ifdef AUTO_CYCLE_EN
        for (int t = 1; t <= 7; t++)
            tick("auto", (t == 3 || t == 6), (t < 3) ? 2'd0 : (t < 6) ? 2'd1 : 2'd2, 10'd304, 10'd224);
        tick("auto_8", 1'b0, 2'd2, 10'd304, 10'd224);
        do_reset();
        tick("auto_r1", 1'b0, 2'd0, 10'd304, 10'd224);
        tick("auto_r2", 1'b0, 2'd0, 10'd304, 10'd224);
        tick("auto_r3", 1'b1, 2'd1, 10'd304, 10'd224);
`else
        press(M_RT);
        tick("right", 1'b1, 2'd0, 10'd312, 10'd224);

        do_reset();
        @(posedge clk); #1;
        gfx.right = 1'b1; repeat (2) @(posedge clk); #1;
        gfx.right = 1'b0; repeat (2) @(posedge clk); #1;
        gfx.right = 1'b1; repeat (10) @(posedge clk); #1;
        gfx.right = 1'b0; repeat (10) @(posedge clk);
        tick("bounce", 1'b1, 2'd0, 10'd312, 10'd224);

        press(M_RT);
        press(M_RT);
        tick("collapse", 1'b1, 2'd0, 10'd320, 10'd224);
        press(M_UP);
        tick("up", 1'b1, 2'd0, 10'd320, 10'd216);
        press(M_DN);
        tick("down", 1'b1, 2'd0, 10'd320, 10'd224);
        press(M_UP | M_DN);
        tick("up_down", 1'b0, 2'd0, 10'd320, 10'd224);

        do_reset();
        for (int k = 1; k <= 38; k++) begin
            press(M_LF);
            tick("left_walk", 1'b1, 2'd0, 10'(304 - 8 * k), 10'd224);
        end
        press(M_LF);
        tick("left_clamp", 1'b0, 2'd0, 10'd0, 10'd224);

        do_reset();
        for (int k = 1; k <= 37; k++) begin
            press(M_RT);
            tick("right_walk", 1'b1, 2'd0, 10'(304 + 8 * k), 10'd224);
        end
        press(M_RT);
        tick("right_608", 1'b1, 2'd0, 10'd608, 10'd224);
        press(M_RT);
        tick("right_clamp", 1'b0, 2'd0, 10'd608, 10'd224);

        for (int k = 1; k <= 28; k++) begin
            press(M_DN);
            tick("down_walk", 1'b1, 2'd0, 10'd608, 10'(224 + 8 * k));
        end
        press(M_DN);
        tick("down_clamp", 1'b0, 2'd0, 10'd608, 10'd448);

        do_reset();
        press(M_SEL);
        tick("sel1", 1'b1, 2'd1, 10'd304, 10'd224);
        press(M_SEL);
        tick("sel2", 1'b1, 2'd2, 10'd304, 10'd224);
        press(M_SEL);
        tick("sel3", 1'b1, 2'd3, 10'd304, 10'd224);
        press(M_LF | M_RT | M_SEL);
        tick("lr_sel_wrap", 1'b1, 2'd0, 10'd304, 10'd224);

        press(M_RT);
        do_reset();
        tick("reset_discard", 1'b0, 2'd0, 10'd304, 10'd224);
`endif

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got %0d pending entries required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
